output_data_serializer: RTL and testbench

- Downstream stage of the output data organizer: accepts one right-aligned rate block per handshake and streams it out as 32-bit words, most-significant word first.
- The block holds data_i[r-1:0], where r is the rate in bits.
- Marks message end and trims the final partial block with a byte keep mask.
- Sits between the output data organizer and the external ciphertext/tag/digest stream interface.

---
 rtl/ascon_pack.sv | 29 ++
 rtl/oser_keep_gen.sv | 28 ++
 rtl/output_data_serializer.sv | 175 +++++++++++++++++
 tb/tb_output_data_serializer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared constants, FSM state type and keep-mask helper for the output data serializer.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package ascon_pack;

  localparam int OUT_W_C      = 32;
  localparam int RATE_MAX_C   = 256;
  localparam int KEEP_W_C     = OUT_W_C / 8;
  localparam int NWORDS_MAX_C = RATE_MAX_C / OUT_W_C;
  localparam int WIDX_W_C     = $clog2(NWORDS_MAX_C);
  localparam int WCNT_W_C     = WIDX_W_C + 1;
  localparam int NBYTES_W_C   = $clog2(RATE_MAX_C / 8) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } oser_state_t;

  // Leading-bytes mask: rem valid bytes starting at the most significant byte.
  function automatic logic [KEEP_W_C-1:0] keep_from_rem(input logic [NBYTES_W_C-1:0] rem);
    logic [KEEP_W_C-1:0] k;
    k = '0;
    for (int i = 0; i < KEEP_W_C; i++) begin
      if (NBYTES_W_C'(i) < rem) k[KEEP_W_C-1-i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/oser_keep_gen.sv
// Keep-mask and final-word decode for the word currently being emitted.
// Latency: purely combinational.
// Backpressure: none; outputs follow the serializer's registered counters.
module oser_keep_gen
  import ascon_pack::*;
(
  input  logic [NBYTES_W_C-1:0] i_nbytes,
  input  logic [WCNT_W_C-1:0]   i_emitted,
  input  logic [WCNT_W_C-1:0]   i_ewords,
  input  logic                  i_last,
  output logic [KEEP_W_C-1:0]   o_keep,
  output logic                  o_last_word
);

  logic [WCNT_W_C-1:0]   w_ewords_eff;
  logic [NBYTES_W_C-1:0] w_rem;

  // An empty last block still emits one word, so the word count never drops below one;
  // with nbytes=0 the remainder is 0 and the keep mask comes out all zero.
  always_comb begin
    w_ewords_eff = (i_ewords == '0) ? WCNT_W_C'(1) : i_ewords;
    o_last_word  = (i_emitted == (w_ewords_eff - WCNT_W_C'(1)));
    w_rem        = i_nbytes - NBYTES_W_C'((w_ewords_eff - WCNT_W_C'(1)) * KEEP_W_C);
    o_keep       = '1;
    if (i_last && o_last_word) o_keep = keep_from_rem(w_rem);
  end

endmodule

// File: rtl/output_data_serializer.sv
// Streams one right-aligned rate block per input handshake as MSB-first OUT_W-bit words with keep/last.
// Latency: first word valid 1 cycle after the input handshake; one word per cycle when out_ready_i stays high.
// Backpressure: out_ready_i low holds the word stable; data_ready_o opens in IDLE or on the accepted final word.
// Optional feature macro: OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN adds byte_count_o (bytes emitted in the message).
module output_data_serializer
  import ascon_pack::*;
#(
  parameter int OUT_W = OUT_W_C,     // fixed at 32; widths below assume the package constants
  parameter int MAX_R = RATE_MAX_C   // fixed at 256; equals the data_i width
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               data_valid_i,
  output logic               data_ready_o,
  input  logic [7:0]         size_treated_data_r_i,
  input  logic [MAX_R-1:0]   data_i,
  input  logic               last_i,
  input  logic [5:0]         last_bytes_i,
  output logic [OUT_W-1:0]   out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [OUT_W/8-1:0] out_keep_o,
  output logic               out_last_o,
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
  output logic [15:0]        byte_count_o,
`endif
  output logic               busy_o
);

  localparam int KW = OUT_W / 8;

  oser_state_t           r_state;
  oser_state_t           w_state_nxt;
  logic [MAX_R-1:0]      r_block;
  logic [WIDX_W_C-1:0]   r_k;
  logic [WCNT_W_C-1:0]   r_emitted;
  logic [WCNT_W_C-1:0]   r_ewords;
  logic [NBYTES_W_C-1:0] r_nbytes;
  logic                  r_last;

  logic [8:0]            w_rate;
  logic [WCNT_W_C-1:0]   w_nwords;
  logic [WCNT_W_C-1:0]   w_ewords;
  logic [WIDX_W_C-1:0]   w_k_init;
  logic [NBYTES_W_C-1:0] w_rate_bytes;
  logic [NBYTES_W_C-1:0] w_nbytes;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_last_word;
  logic [KW-1:0]         w_keep;
  logic [OUT_W-1:0]      w_word;

  // Decode the incoming rate into word/byte counts for the block about to be captured.
  always_comb begin
    w_rate       = (size_treated_data_r_i == 8'd0) ? 9'd256 : {1'b0, size_treated_data_r_i};
    w_nwords     = WCNT_W_C'(32'(w_rate) / OUT_W);
    w_k_init     = WIDX_W_C'(w_nwords - WCNT_W_C'(1));
    w_rate_bytes = NBYTES_W_C'(w_rate >> 3);
    w_nbytes     = w_rate_bytes;
    if (last_i && (last_bytes_i < w_rate_bytes)) w_nbytes = last_bytes_i;
    w_ewords     = WCNT_W_C'((32'(w_nbytes) + KW - 1) / KW);
  end

  oser_keep_gen u_keep_gen (
    .i_nbytes    (r_nbytes),
    .i_emitted   (r_emitted),
    .i_ewords    (r_ewords),
    .i_last      (r_last),
    .o_keep      (w_keep),
    .o_last_word (w_last_word)
  );

  assign w_word   = r_block[r_k*OUT_W +: OUT_W];
  assign w_in_hs  = data_valid_i && data_ready_o;
  assign w_out_hs = out_valid_o && out_ready_i;

  // State register.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state and outputs; everything is forced low while reset is held.
  always_comb begin
    w_state_nxt  = r_state;
    data_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    busy_o       = 1'b0;
    out_data_o   = '0;
    out_keep_o   = '0;
    out_last_o   = 1'b0;
    if (resetb_i) begin
      case (r_state)
        IDLE: begin
          data_ready_o = 1'b1;
          if (data_valid_i) w_state_nxt = SEND;
        end
        SEND: begin
          out_valid_o  = 1'b1;
          busy_o       = 1'b1;
          out_keep_o   = w_keep;
          out_last_o   = r_last && w_last_word;
          for (int b = 0; b < KW; b++) begin
            out_data_o[8*b +: 8] = w_word[8*b +: 8] & {8{w_keep[b]}};
          end
          // Opening ready on the accepted final word lets the next block follow with no bubble.
          data_ready_o = w_last_word && out_ready_i;
          if (out_ready_i && w_last_word && !data_valid_i) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Block capture and word walk; a new capture always wins since it only happens on the final word.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_block   <= '0;
      r_k       <= '0;
      r_emitted <= '0;
      r_ewords  <= '0;
      r_nbytes  <= '0;
      r_last    <= 1'b0;
    end else if (w_in_hs) begin
      r_block   <= data_i;
      r_k       <= w_k_init;
      r_emitted <= '0;
      r_ewords  <= w_ewords;
      r_nbytes  <= w_nbytes;
      r_last    <= last_i;
    end else if (w_out_hs) begin
      r_k       <= r_k - WIDX_W_C'(1);
      r_emitted <= r_emitted + WCNT_W_C'(1);
    end
  end

  // Flag rates that do not split into whole output words.
  always_ff @(posedge clock_i) begin
    if (resetb_i && w_in_hs) begin
      assert ((32'(w_rate) % OUT_W) == 0)
        else $error("output_data_serializer: rate %0d is not a multiple of %0d", w_rate, OUT_W);
    end
  end

`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
  logic [15:0] r_byte_cnt;
  logic        r_bc_clear;
  logic [7:0]  w_pop;
  logic [15:0] w_bc_base;
  logic [16:0] w_bc_sum;

  // Popcount of the emitted keep added to the running total (restarting after a message end).
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < KW; b++) w_pop = w_pop + 8'(out_keep_o[b]);
    w_bc_base = r_bc_clear ? 16'd0 : r_byte_cnt;
    w_bc_sum  = {1'b0, w_bc_base} + 17'(w_pop);
  end

  // Running byte count: saturates, and clears the cycle after the last word is accepted.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_byte_cnt <= '0;
      r_bc_clear <= 1'b0;
    end else begin
      r_bc_clear <= w_out_hs && out_last_o;
      if (w_out_hs) r_byte_cnt <= w_bc_sum[16] ? 16'hFFFF : w_bc_sum[15:0];
      else          r_byte_cnt <= w_bc_base;
    end
  end

  assign byte_count_o = resetb_i ? r_byte_cnt : 16'd0;
`endif

endmodule

// File: tb/tb_output_data_serializer.sv
`timescale 1ns/1ps
module tb_output_data_serializer;

  logic         clock_i = 1'b0;
  logic         resetb_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic [7:0]   size_treated_data_r_i;
  logic [255:0] data_i;
  logic         last_i;
  logic [5:0]   last_bytes_i;
  logic [31:0]  out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [3:0]   out_keep_o;
  logic         out_last_o;
  logic         busy_o;
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
  logic [15:0]  byte_count_o;
`endif

  always #5 clock_i = ~clock_i;

  output_data_serializer dut (
    .clock_i               (clock_i),
    .resetb_i              (resetb_i),
    .data_valid_i          (data_valid_i),
    .data_ready_o          (data_ready_o),
    .size_treated_data_r_i (size_treated_data_r_i),
    .data_i                (data_i),
    .last_i                (last_i),
    .last_bytes_i          (last_bytes_i),
    .out_data_o            (out_data_o),
    .out_valid_o           (out_valid_o),
    .out_ready_i           (out_ready_i),
    .out_keep_o            (out_keep_o),
    .out_last_o            (out_last_o),
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
    .byte_count_o          (byte_count_o),
`endif
    .busy_o                (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Blocks to send and the expected word stream derived from them.
  int           b_r[$];
  logic [255:0] b_d[$];
  bit           b_l[$];
  int           b_lb[$];
  logic [31:0]  e_dat[$];
  logic [3:0]   e_keep[$];
  bit           e_last[$];
  // Observed word stream.
  logic [31:0]  g_dat[$];
  logic [3:0]   g_keep[$];
  bit           g_last[$];
  bit           g_rdy[$];
  int           g_bc[$];
  int           gaps;
  int           stall_bad;
  bit           timed_out;

  // Reference: the block is a byte string read MSB-first from bit r-1; the first nbytes bytes are
  // sent, packed four per word and zero-padded; an empty last block yields one empty word.
  function automatic void model(input int r_enc, input logic [255:0] d, input bit lst, input int lb);
    int rb, nb, nw, p;
    logic [31:0] w;
    logic [3:0]  k;
    rb = (r_enc == 0) ? 256 : r_enc;
    nb = rb / 8;
    if (lst && lb < nb) nb = lb;
    nw = (nb + 3) / 4;
    if (nw == 0) nw = 1;
    for (int j = 0; j < nw; j++) begin
      w = '0;
      k = '0;
      for (int q = 0; q < 4; q++) begin
        p = 4 * j + q;
        if (p < nb) begin
          w[31-8*q -: 8] = d[rb-1-8*p -: 8];
          k[3-q] = 1'b1;
        end
      end
      e_dat.push_back(w);
      e_keep.push_back(k);
      e_last.push_back(lst && (j == nw - 1));
    end
  endfunction

  task automatic clear_blocks();
    b_r.delete(); b_d.delete(); b_l.delete(); b_lb.delete();
    e_dat.delete(); e_keep.delete(); e_last.delete();
  endtask

  task automatic add_block(input int r_enc, input logic [255:0] d, input bit lst, input int lb);
    b_r.push_back(r_enc); b_d.push_back(d); b_l.push_back(lst); b_lb.push_back(lb);
    model(r_enc, d, lst, lb);
  endtask

  // Drives the queued blocks and records every accepted output word.
  // mode 0: ready always high, 1: ready toggles 1,0,1,0..., 2: random ready.
  task automatic run_stream(input bit vrand, input int mode);
    int cyc = 0;
    int bi = 0;
    bit hold_v = 1'b0;
    logic [31:0] hd = '0;
    logic [3:0] hk = '0;
    logic hl = 1'b0;
    bit seen = 1'b0;
    int pend = 0;
    bit in_hs;
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
    bit bc_pend = 1'b0;
`endif
    g_dat.delete(); g_keep.delete(); g_last.delete(); g_rdy.delete(); g_bc.delete();
    gaps = 0; stall_bad = 0; timed_out = 1'b0;
    forever begin
      @(negedge clock_i);
      if (bi < b_r.size() && (!vrand || ($urandom_range(0, 1) == 1))) begin
        data_valid_i          = 1'b1;
        size_treated_data_r_i = 8'(b_r[bi]);
        data_i                = b_d[bi];
        last_i                = b_l[bi];
        last_bytes_i          = 6'(b_lb[bi]);
      end else begin
        data_valid_i = 1'b0;
      end
      case (mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = (cyc % 2 == 0);
        default: out_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      #1;
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
      if (bc_pend) g_bc.push_back(int'(byte_count_o));
      bc_pend = 1'b0;
`endif
      if (hold_v && (out_valid_o !== 1'b1 || out_data_o !== hd || out_keep_o !== hk || out_last_o !== hl))
        stall_bad++;
      hold_v = out_valid_o && !out_ready_i;
      hd = out_data_o; hk = out_keep_o; hl = out_last_o;
      if (out_valid_o) begin
        if (seen) gaps += pend;
        pend = 0;
        seen = 1'b1;
      end else if (seen) begin
        pend++;
      end
      if (out_valid_o && out_ready_i) begin
        g_dat.push_back(out_data_o);
        g_keep.push_back(out_keep_o);
        g_last.push_back(out_last_o);
        g_rdy.push_back(data_ready_o);
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
        bc_pend = 1'b1;
`endif
      end
      in_hs = data_valid_i && data_ready_o;
      if (in_hs) bi++;
      cyc++;
      if (bi == b_r.size() && !in_hs && !out_valid_o) break;
      if (cyc > 3000) begin
        timed_out = 1'b1;
        break;
      end
    end
    data_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    resetb_i = 1'b0; data_valid_i = 1'b1; out_ready_i = 1'b1;
    size_treated_data_r_i = 8'd64; data_i = {8{32'hDEADBEEF}}; last_i = 1'b1; last_bytes_i = 6'd8;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i); #1;
    n_tests++;
    if ({out_valid_o, data_ready_o, busy_o, out_last_o, out_keep_o, out_data_o} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%b rdy=%b busy=%b last=%b keep=%b data=%h, required all 0",
               out_valid_o, data_ready_o, busy_o, out_last_o, out_keep_o, out_data_o);
    end
    @(negedge clock_i);
    resetb_i = 1'b1; data_valid_i = 1'b0;
    #1;
    n_tests++;
    if ({data_ready_o, out_valid_o, busy_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b busy=%b, required 1 0 0", data_ready_o, out_valid_o, busy_o);
    end
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
    n_tests++;
    if (byte_count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_bytecount: got %0d required 0", byte_count_o);
    end
`endif
  endtask

  task automatic test_directed();
    // 64-bit full block.
    clear_blocks();
    add_block(64, 256'h0011223344556677, 1'b0, 0);
    run_stream(1'b0, 0);
    n_tests++;
    if (timed_out || g_dat.size() != 2) begin
      n_fail++;
      $display("FAIL dir64_count: got %0d words (timeout=%b), required 2", g_dat.size(), timed_out);
    end else begin
      n_tests++;
      if ({g_dat[0], g_keep[0], g_last[0]} !== {32'h00112233, 4'b1111, 1'b0}) begin
        n_fail++;
        $display("FAIL dir64_w0: got %h/%b/%b required 00112233/1111/0", g_dat[0], g_keep[0], g_last[0]);
      end
      n_tests++;
      if ({g_dat[1], g_keep[1], g_last[1], g_rdy[1]} !== {32'h44556677, 4'b1111, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL dir64_w1: got %h/%b/%b rdy=%b required 44556677/1111/0 rdy=1",
                 g_dat[1], g_keep[1], g_last[1], g_rdy[1]);
      end
    end
    // 128-bit last block with 5 valid bytes.
    clear_blocks();
    add_block(128, 256'hAABBCCDD_EEFF0011_22334455_66778899, 1'b1, 5);
    run_stream(1'b0, 0);
    n_tests++;
    if (timed_out || g_dat.size() != 2) begin
      n_fail++;
      $display("FAIL dir128_count: got %0d words (timeout=%b), required 2", g_dat.size(), timed_out);
    end else begin
      n_tests++;
      if ({g_dat[0], g_keep[0], g_last[0]} !== {32'hAABBCCDD, 4'b1111, 1'b0}) begin
        n_fail++;
        $display("FAIL dir128_w0: got %h/%b/%b required AABBCCDD/1111/0", g_dat[0], g_keep[0], g_last[0]);
      end
      n_tests++;
      if ({g_dat[1], g_keep[1], g_last[1]} !== {32'hEE000000, 4'b1000, 1'b1}) begin
        n_fail++;
        $display("FAIL dir128_w1: got %h/%b/%b required EE000000/1000/1", g_dat[1], g_keep[1], g_last[1]);
      end
    end
    // Empty last block.
    clear_blocks();
    add_block(64, {8{32'hFFFFFFFF}}, 1'b1, 0);
    run_stream(1'b0, 0);
    n_tests++;
    if (timed_out || g_dat.size() != 1) begin
      n_fail++;
      $display("FAIL empty_count: got %0d words (timeout=%b), required 1", g_dat.size(), timed_out);
    end else begin
      n_tests++;
      if ({g_dat[0], g_keep[0], g_last[0]} !== {32'h0, 4'b0000, 1'b1}) begin
        n_fail++;
        $display("FAIL empty_w0: got %h/%b/%b required 00000000/0000/1", g_dat[0], g_keep[0], g_last[0]);
      end
    end
  endtask

  task automatic test_stall_256();
    logic [255:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    clear_blocks();
    add_block(0, d, 1'b0, 0);
    run_stream(1'b0, 1);
    n_tests++;
    if (timed_out || g_dat.size() != 8 || stall_bad != 0) begin
      n_fail++;
      $display("FAIL stall256_stream: got %0d words, %0d unstable stalls, timeout=%b; required 8, 0, 0",
               g_dat.size(), stall_bad, timed_out);
    end
    for (int i = 0; i < g_dat.size() && i < e_dat.size(); i++) begin
      n_tests++;
      if ({g_dat[i], g_keep[i], g_last[i]} !== {e_dat[i], e_keep[i], e_last[i]}) begin
        n_fail++;
        $display("FAIL stall256_w%0d: got %h/%b/%b required %h/%b/%b", i,
                 g_dat[i], g_keep[i], g_last[i], e_dat[i], e_keep[i], e_last[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_blocks();
    add_block(64, {8{$urandom()}}, 1'b0, 0);
    add_block(64, {8{$urandom()}}, 1'b1, 8);
    run_stream(1'b0, 0);
    n_tests++;
    if (timed_out || g_dat.size() != 4 || gaps != 0) begin
      n_fail++;
      $display("FAIL b2b_stream: got %0d words, %0d idle cycles, timeout=%b; required 4, 0, 0",
               g_dat.size(), gaps, timed_out);
    end
    for (int i = 0; i < g_dat.size() && i < e_dat.size(); i++) begin
      n_tests++;
      if ({g_dat[i], g_keep[i], g_last[i]} !== {e_dat[i], e_keep[i], e_last[i]}) begin
        n_fail++;
        $display("FAIL b2b_w%0d: got %h/%b/%b required %h/%b/%b", i,
                 g_dat[i], g_keep[i], g_last[i], e_dat[i], e_keep[i], e_last[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    @(negedge clock_i);
    data_valid_i = 1'b1; size_treated_data_r_i = 8'd128; last_i = 1'b1; last_bytes_i = 6'd16;
    data_i = {8{$urandom()}}; out_ready_i = 1'b1;
    @(negedge clock_i);
    data_valid_i = 1'b0;
    #1;
    n_tests++;
    if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_latency: got v=%b busy=%b one cycle after capture, required 1 1", out_valid_o, busy_o);
    end
    @(negedge clock_i);
    resetb_i = 1'b0;
    @(negedge clock_i);
    resetb_i = 1'b1;
    #1;
    n_tests++;
    if ({out_valid_o, data_ready_o, busy_o, out_last_o} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_after: got v=%b rdy=%b busy=%b last=%b, required 0 1 0 0",
               out_valid_o, data_ready_o, busy_o, out_last_o);
    end
    repeat (6) begin
      @(negedge clock_i); #1;
      if (out_valid_o || out_last_o) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrst_drop: got %0d cycles with output activity, required 0", bad);
    end
  endtask

  task automatic test_random();
    int rr;
    clear_blocks();
    for (int i = 0; i < 40; i++) begin
      rr = $urandom_range(1, 8) * 32;
      add_block((rr == 256) ? 0 : rr,
                {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                bit'($urandom_range(0, 1)), $urandom_range(0, 32));
    end
    run_stream(1'b1, 2);
    n_tests++;
    if (timed_out || g_dat.size() != e_dat.size() || stall_bad != 0) begin
      n_fail++;
      $display("FAIL rand_stream: got %0d words, %0d unstable stalls, timeout=%b; required %0d, 0, 0",
               g_dat.size(), stall_bad, timed_out, e_dat.size());
    end
    for (int i = 0; i < g_dat.size() && i < e_dat.size(); i++) begin
      n_tests++;
      if ({g_dat[i], g_keep[i], g_last[i]} !== {e_dat[i], e_keep[i], e_last[i]}) begin
        n_fail++;
        $display("FAIL rand_w%0d: got %h/%b/%b required %h/%b/%b", i,
                 g_dat[i], g_keep[i], g_last[i], e_dat[i], e_keep[i], e_last[i]);
      end
    end
  endtask

`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
  task automatic test_byte_count();
    clear_blocks();
    add_block(64, {8{$urandom()}}, 1'b0, 0);
    add_block(64, {8{$urandom()}}, 1'b1, 3);
    run_stream(1'b0, 0);
    n_tests++;
    if (g_bc.size() != 3) begin
      n_fail++;
      $display("FAIL bytecount_samples: got %0d samples required 3", g_bc.size());
    end else begin
      n_tests++;
      if (g_bc[0] != 4 || g_bc[1] != 8 || g_bc[2] != 11) begin
        n_fail++;
        $display("FAIL bytecount_run: got %0d,%0d,%0d required 4,8,11", g_bc[0], g_bc[1], g_bc[2]);
      end
    end
    @(negedge clock_i); #1;
    n_tests++;
    if (byte_count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL bytecount_clear: got %0d required 0", byte_count_o);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall_256();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef OUTPUT_DATA_SERIALIZER_BYTE_COUNT_EN
    test_byte_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
